// File: rtl/rv32i_pkg.sv
// rv32i_pkg: shared types for the RV32I core slice.
//   lsu_size_e      - load/store size/sign encodings (funct3 = inst[14:12])
//   lsu_state_e     - load/store unit handshake states
//   LSU_TIMEOUT_DEF - default memory timeout in cycles
//   lsu_bad_access  - illegal-size or misaligned access detect
package rv32i_pkg;

    typedef enum logic [2:0] {
        LB  = 3'b000,
        LH  = 3'b001,
        LW  = 3'b010,
        LBU = 3'b100,
        LHU = 3'b101
    } lsu_size_e;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT_R,
        RESP
    } lsu_state_e;

    localparam int LSU_TIMEOUT_DEF = 255;

    // Returns 1 when the access must be answered with an error and never
    // reach memory. Stores have no unsigned forms, so only 000/001/010 are legal.
    function automatic logic lsu_bad_access(input logic       st,
                                            input logic [2:0] funct3,
                                            input logic [1:0] off);
        logic illegal;
        logic misalign;
        if (st)
            illegal = (funct3 > 3'b010);
        else
            illegal = (funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111);
        misalign = ((funct3[1:0] == 2'b01) && off[0]) ||
                   ((funct3[1:0] == 2'b10) && (off != 2'b00));
        return illegal || misalign;
    endfunction

endpackage

// File: rtl/lsu_load_align.sv
// lsu_load_align: combinational load-data extraction.
//   funct3 in  3   access size/sign
//   off    in  2   byte offset within the word
//   rdata  in  32  raw memory word
//   data   out 32  shifted and sign/zero-extended load result
module lsu_load_align
    import rv32i_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  off,
    input  logic [31:0] rdata,
    output logic [31:0] data
);

    logic [31:0] d;

    // Bring the addressed byte/half down to bit 0.
    assign d = rdata >> {off, 3'b000};

    always_comb begin
        data = d;
        case (funct3)
            LB:      data = {{24{d[7]}}, d[7:0]};
            LH:      data = {{16{d[15]}}, d[15:0]};
            LBU:     data = {24'h0, d[7:0]};
            LHU:     data = {16'h0, d[15:0]};
            default: data = d;
        endcase
    end

endmodule

// File: rtl/lsu_mem_ctrl.sv
// lsu_mem_ctrl: load/store unit responder for a single-port word memory.
// Accepts one request at a time, runs a req/gnt then rvalid handshake, and
// returns a one-cycle tagged response to writeback.
//   i_clk, i_rst                 clock, synchronous active-high reset
//   lsu_VALID / lsu_READY        request handshake from execute
//   i_st_mem, i_funct3, i_addr,
//   i_wdata, i_rd                request fields, registered at accept
//   o_rsp_vld/data/rd/err        one-cycle response strobe and payload
//   o_mem_req/we/addr/be/wdata   memory request, valid only in REQ
//   i_mem_gnt, i_mem_rvalid,
//   i_mem_rdata                  memory grant and read return
module lsu_mem_ctrl
    import rv32i_pkg::*;
#(
    parameter int TIMEOUT_CYC = LSU_TIMEOUT_DEF,
    parameter int TIMER_W     = 8
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        lsu_VALID,
    output logic        lsu_READY,
    input  logic        i_st_mem,
    input  logic [2:0]  i_funct3,
    input  logic [31:0] i_addr,
    input  logic [31:0] i_wdata,
    input  logic [4:0]  i_rd,
    output logic        o_rsp_vld,
    output logic [31:0] o_rsp_data,
    output logic [4:0]  o_rsp_rd,
    output logic        o_rsp_err,
    output logic        o_mem_req,
    output logic        o_mem_we,
    output logic [29:0] o_mem_addr,
    output logic [3:0]  o_mem_be,
    output logic [31:0] o_mem_wdata,
    input  logic        i_mem_gnt,
    input  logic        i_mem_rvalid,
    input  logic [31:0] i_mem_rdata
);

    // The timer holds the number of REQ/WAIT_R cycles already spent, so the
    // timeout fires in the TIMEOUT_CYC-th such cycle.
    localparam bit               TO_EN   = (TIMEOUT_CYC > 0);
    localparam logic [TIMER_W-1:0] TO_LAST =
        TIMER_W'((TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0);

    lsu_state_e         state_q, state_d;
    logic [TIMER_W-1:0] timer_q;
    logic               st_q;
    logic [2:0]         f3_q;
    logic [1:0]         off_q;
    logic [29:0]        addr_q;
    logic [3:0]         be_q;
    logic [31:0]        wdata_q;
    logic [4:0]         rd_q;
    logic [31:0]        rsp_data_q;
    logic               rsp_err_q;

    logic               accept;
    logic               acc_bad;
    logic               timeout_hit;
    logic [3:0]         st_be;
    logic [31:0]        st_wdata;
    logic [31:0]        ld_data;
    logic               in_req;
    logic               in_resp;

    assign lsu_READY   = (state_q == IDLE) & ~i_rst;
    assign accept      = lsu_VALID & lsu_READY;
    assign acc_bad     = lsu_bad_access(i_st_mem, i_funct3, i_addr[1:0]);
    assign timeout_hit = TO_EN && (timer_q == TO_LAST);

    // Byte-lane steering: replicate narrow data across the word so the
    // enabled lanes always carry the right bytes.
    always_comb begin
        st_be    = 4'b1111;
        st_wdata = i_wdata;
        case (i_funct3[1:0])
            2'b00: begin
                st_be    = 4'b0001 << i_addr[1:0];
                st_wdata = {4{i_wdata[7:0]}};
            end
            2'b01: begin
                st_be    = 4'b0011 << i_addr[1:0];
                st_wdata = {2{i_wdata[15:0]}};
            end
            default: ;
        endcase
    end

    lsu_load_align u_align (
        .funct3 (f3_q),
        .off    (off_q),
        .rdata  (i_mem_rdata),
        .data   (ld_data)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    // Grant/rvalid take priority over a timeout landing in the same cycle.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = acc_bad ? RESP : REQ;
            REQ: begin
                if (i_mem_gnt)        state_d = st_q ? RESP : WAIT_R;
                else if (timeout_hit) state_d = RESP;
            end
            WAIT_R: begin
                if (i_mem_rvalid)     state_d = RESP;
                else if (timeout_hit) state_d = RESP;
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            timer_q    <= '0;
            st_q       <= 1'b0;
            f3_q       <= '0;
            off_q      <= '0;
            addr_q     <= '0;
            be_q       <= '0;
            wdata_q    <= '0;
            rd_q       <= '0;
            rsp_data_q <= '0;
            rsp_err_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        timer_q    <= '0;
                        st_q       <= i_st_mem;
                        f3_q       <= i_funct3;
                        off_q      <= i_addr[1:0];
                        addr_q     <= i_addr[31:2];
                        be_q       <= st_be;
                        wdata_q    <= i_st_mem ? st_wdata : 32'h0;
                        rd_q       <= i_rd;
                        rsp_data_q <= '0;
                        rsp_err_q  <= acc_bad;
                    end
                end
                REQ: begin
                    timer_q <= timer_q + 1'b1;
                    if (!i_mem_gnt && timeout_hit) rsp_err_q <= 1'b1;
                end
                WAIT_R: begin
                    timer_q <= timer_q + 1'b1;
                    if (i_mem_rvalid)     rsp_data_q <= ld_data;
                    else if (timeout_hit) rsp_err_q  <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign in_req      = (state_q == REQ);
    assign in_resp     = (state_q == RESP);

    assign o_mem_req   = in_req;
    assign o_mem_we    = in_req & st_q;
    assign o_mem_addr  = in_req ? addr_q  : 30'h0;
    assign o_mem_be    = in_req ? be_q    : 4'h0;
    assign o_mem_wdata = in_req ? wdata_q : 32'h0;

    assign o_rsp_vld   = in_resp;
    assign o_rsp_data  = in_resp ? rsp_data_q : 32'h0;
    assign o_rsp_rd    = in_resp ? rd_q       : 5'h0;
    assign o_rsp_err   = in_resp & rsp_err_q;

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
module tb_lsu_mem_ctrl;

    logic        i_clk = 1'b0;
    logic        i_rst = 1'b1;
    logic        lsu_VALID = 1'b0;
    logic        lsu_READY;
    logic        i_st_mem = 1'b0;
    logic [2:0]  i_funct3 = '0;
    logic [31:0] i_addr = '0;
    logic [31:0] i_wdata = '0;
    logic [4:0]  i_rd = '0;
    logic        o_rsp_vld;
    logic [31:0] o_rsp_data;
    logic [4:0]  o_rsp_rd;
    logic        o_rsp_err;
    logic        o_mem_req;
    logic        o_mem_we;
    logic [29:0] o_mem_addr;
    logic [3:0]  o_mem_be;
    logic [31:0] o_mem_wdata;
    logic        i_mem_gnt = 1'b0;
    logic        i_mem_rvalid = 1'b0;
    logic [31:0] i_mem_rdata = '0;

    int vec_n  = 0;
    int miss_n = 0;

    typedef struct {
        logic [31:0] data;
        logic [4:0]  rd;
        logic        err;
        int          lat;
    } exp_t;

    typedef struct {
        logic        seen;
        int          lat;
        logic [31:0] data;
        logic [4:0]  rd;
        logic        err;
        logic        rdy;
        logic        rdy_resp;
        int          req_cnt;
        logic [29:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic        we;
        logic        unstable;
    } obs_t;

    exp_t exp_q[$];

    lsu_mem_ctrl #(.TIMEOUT_CYC(4), .TIMER_W(8)) dut (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .lsu_VALID    (lsu_VALID),
        .lsu_READY    (lsu_READY),
        .i_st_mem     (i_st_mem),
        .i_funct3     (i_funct3),
        .i_addr       (i_addr),
        .i_wdata      (i_wdata),
        .i_rd         (i_rd),
        .o_rsp_vld    (o_rsp_vld),
        .o_rsp_data   (o_rsp_data),
        .o_rsp_rd     (o_rsp_rd),
        .o_rsp_err    (o_rsp_err),
        .o_mem_req    (o_mem_req),
        .o_mem_we     (o_mem_we),
        .o_mem_addr   (o_mem_addr),
        .o_mem_be     (o_mem_be),
        .o_mem_wdata  (o_mem_wdata),
        .i_mem_gnt    (i_mem_gnt),
        .i_mem_rvalid (i_mem_rvalid),
        .i_mem_rdata  (i_mem_rdata)
    );

    always #5 i_clk = ~i_clk;

    // Advance to just after the next rising edge: outputs for the new cycle
    // are settled, and inputs set now are seen at the following edge.
    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    // Reference load extraction written with byte/half selects.
    function automatic logic [31:0] exp_load(input logic [2:0] f3, input logic [1:0] off,
                                             input logic [31:0] w);
        logic [7:0]  b;
        logic [15:0] h;
        b = w[int'(off) * 8 +: 8];
        h = off[1] ? w[31:16] : w[15:0];
        case (f3)
            3'b000:  return {{24{b[7]}}, b};
            3'b100:  return {24'h0, b};
            3'b001:  return {{16{h[15]}}, h};
            3'b101:  return {16'h0, h};
            default: return w;
        endcase
    endfunction

    // Issues one request and plays the memory side: gnt after gnt_dly REQ
    // cycles (-1 = never), rvalid rv_dly cycles after gnt (0 = never).
    // Records what the DUT did; the calling test does the comparing.
    task automatic do_xact(input logic st, input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [4:0] rd,
                           input int gnt_dly, input int rv_dly, input logic [31:0] rdata,
                           output obs_t o);
        int g;
        o = '{seen: 1'b0, lat: -1, data: '0, rd: '0, err: 1'b0, rdy: 1'b0, rdy_resp: 1'b0,
              req_cnt: 0, addr: '0, be: '0, wdata: '0, we: 1'b0, unstable: 1'b0};
        g = -1;
        tick();
        o.rdy     = lsu_READY;
        lsu_VALID = 1'b1;
        i_st_mem  = st;
        i_funct3  = f3;
        i_addr    = addr;
        i_wdata   = wdata;
        i_rd      = rd;
        for (int k = 1; k <= 20 && !o.seen; k++) begin
            tick();
            lsu_VALID    = 1'b0;
            i_mem_gnt    = 1'b0;
            i_mem_rvalid = 1'b0;
            i_mem_rdata  = 32'h0;
            if (o_rsp_vld) begin
                o.seen     = 1'b1;
                o.lat      = k;
                o.data     = o_rsp_data;
                o.rd       = o_rsp_rd;
                o.err      = o_rsp_err;
                o.rdy_resp = lsu_READY;
            end
            if (o_mem_req) begin
                if (o.req_cnt == 0) begin
                    o.addr = o_mem_addr; o.be = o_mem_be; o.wdata = o_mem_wdata; o.we = o_mem_we;
                end else if (o.addr !== o_mem_addr || o.be !== o_mem_be ||
                             o.wdata !== o_mem_wdata || o.we !== o_mem_we) begin
                    o.unstable = 1'b1;
                end
                if (o.req_cnt == gnt_dly) begin
                    i_mem_gnt = 1'b1;
                    g = k;
                end
                o.req_cnt++;
            end
            if (g >= 0 && rv_dly > 0 && k == g + rv_dly) begin
                i_mem_rvalid = 1'b1;
                i_mem_rdata  = rdata;
            end
        end
        i_mem_gnt    = 1'b0;
        i_mem_rvalid = 1'b0;
    endtask

    task automatic test_reset();
        i_rst = 1'b1;
        tick();
        tick();
        vec_n++;
        if ({o_rsp_vld, o_rsp_err, o_rsp_data, o_rsp_rd} !== '0) begin
            miss_n++; $display("FAIL reset_rsp: got vld=%b err=%b data=%h rd=%0d, want all 0",
                               o_rsp_vld, o_rsp_err, o_rsp_data, o_rsp_rd);
        end
        vec_n++;
        if ({o_mem_req, o_mem_we, o_mem_addr, o_mem_be, o_mem_wdata} !== '0) begin
            miss_n++; $display("FAIL reset_mem: got req=%b we=%b addr=%h be=%b wdata=%h, want all 0",
                               o_mem_req, o_mem_we, o_mem_addr, o_mem_be, o_mem_wdata);
        end
        vec_n++;
        if (lsu_READY !== 1'b0) begin
            miss_n++; $display("FAIL reset_ready_in_rst: got %b want 0", lsu_READY);
        end
        i_rst = 1'b0;
        #1;
        vec_n++;
        if (lsu_READY !== 1'b1) begin
            miss_n++; $display("FAIL reset_ready_after: got %b want 1", lsu_READY);
        end
    endtask

    task automatic test_stores();
        logic [2:0]  f3[4] = '{3'b010, 3'b000, 3'b001, 3'b000};
        logic [31:0] ad[4] = '{32'h100, 32'h103, 32'h102, 32'h101};
        logic [31:0] wd[4] = '{32'hDEADBEEF, 32'h000000A5, 32'h1234ABCD, 32'hFFFF0077};
        int          gd[4] = '{0, 3, 1, 0};
        logic [31:0] ew[4] = '{32'hDEADBEEF, 32'hA5A5A5A5, 32'hABCDABCD, 32'h77777777};
        logic [3:0]  eb[4] = '{4'b1111, 4'b1000, 4'b1100, 4'b0010};
        obs_t o;
        exp_t e;
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back('{data: 32'h0, rd: 5'(i + 1), err: 1'b0, lat: gd[i] + 2});
            do_xact(1'b1, f3[i], ad[i], wd[i], 5'(i + 1), gd[i], 0, 32'h0, o);
            e = exp_q.pop_front();
            vec_n++;
            if (!o.seen || o.lat != e.lat || o.err !== e.err || o.data !== e.data || o.rd !== e.rd) begin
                miss_n++; $display("FAIL store%0d_rsp: got seen=%b lat=%0d err=%b data=%h rd=%0d, want lat=%0d err=%b data=%h rd=%0d",
                                   i, o.seen, o.lat, o.err, o.data, o.rd, e.lat, e.err, e.data, e.rd);
            end
            vec_n++;
            if (o.addr !== ad[i][31:2] || o.be !== eb[i] || o.wdata !== ew[i] || o.we !== 1'b1) begin
                miss_n++; $display("FAIL store%0d_mem: got addr=%h be=%b wdata=%h we=%b, want addr=%h be=%b wdata=%h we=1",
                                   i, o.addr, o.be, o.wdata, o.we, ad[i][31:2], eb[i], ew[i]);
            end
            vec_n++;
            if (o.req_cnt != gd[i] + 1 || o.unstable || o.rdy !== 1'b1 || o.rdy_resp !== 1'b0) begin
                miss_n++; $display("FAIL store%0d_hs: got req_cycles=%0d unstable=%b rdy=%b rdy_in_resp=%b, want %0d 0 1 0",
                                   i, o.req_cnt, o.unstable, o.rdy, o.rdy_resp, gd[i] + 1);
            end
        end
    endtask

    task automatic test_loads();
        logic [2:0]  f3[7] = '{3'b000, 3'b100, 3'b001, 3'b001, 3'b101, 3'b010, 3'b000};
        logic [31:0] ad[7] = '{32'h102, 32'h102, 32'h102, 32'h100, 32'h100, 32'h104, 32'h101};
        logic [31:0] rw[7] = '{32'h12803456, 32'h12803456, 32'h12803456, 32'h1280F456,
                               32'h1280F456, 32'hCAFEF00D, 32'h00007F00};
        logic [31:0] ed[7] = '{32'hFFFFFF80, 32'h00000080, 32'h00001280, 32'hFFFFF456,
                               32'h0000F456, 32'hCAFEF00D, 32'h0000007F};
        obs_t o;
        exp_t e;
        for (int i = 0; i < 7; i++) begin
            exp_q.push_back('{data: ed[i], rd: 5'(7 + i), err: 1'b0, lat: 3});
            do_xact(1'b0, f3[i], ad[i], 32'hFFFFFFFF, 5'(7 + i), 0, 1, rw[i], o);
            e = exp_q.pop_front();
            vec_n++;
            if (!o.seen || o.lat != e.lat || o.err !== e.err || o.data !== e.data || o.rd !== e.rd) begin
                miss_n++; $display("FAIL load%0d_rsp: got seen=%b lat=%0d err=%b data=%h rd=%0d, want lat=%0d err=%b data=%h rd=%0d",
                                   i, o.seen, o.lat, o.err, o.data, o.rd, e.lat, e.err, e.data, e.rd);
            end
            vec_n++;
            if (o.addr !== ad[i][31:2] || o.we !== 1'b0 || o.req_cnt != 1) begin
                miss_n++; $display("FAIL load%0d_mem: got addr=%h we=%b req_cycles=%0d, want addr=%h we=0 req_cycles=1",
                                   i, o.addr, o.we, o.req_cnt, ad[i][31:2]);
            end
        end
    endtask

    task automatic test_errors();
        logic        st[6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        logic [2:0]  f3[6] = '{3'b001, 3'b010, 3'b011, 3'b100, 3'b001, 3'b110};
        logic [31:0] ad[6] = '{32'h101, 32'h102, 32'h100, 32'h100, 32'h103, 32'h200};
        obs_t o;
        exp_t e;
        for (int i = 0; i < 6; i++) begin
            exp_q.push_back('{data: 32'h0, rd: 5'(20 + i), err: 1'b1, lat: 1});
            do_xact(st[i], f3[i], ad[i], 32'h12345678, 5'(20 + i), 0, 1, 32'hFFFFFFFF, o);
            e = exp_q.pop_front();
            vec_n++;
            if (!o.seen || o.lat != e.lat || o.err !== e.err || o.data !== e.data || o.rd !== e.rd) begin
                miss_n++; $display("FAIL err%0d_rsp: got seen=%b lat=%0d err=%b data=%h rd=%0d, want lat=%0d err=%b data=%h rd=%0d",
                                   i, o.seen, o.lat, o.err, o.data, o.rd, e.lat, e.err, e.data, e.rd);
            end
            vec_n++;
            if (o.req_cnt != 0) begin
                miss_n++; $display("FAIL err%0d_noreq: got %0d req cycles, want 0", i, o.req_cnt);
            end
        end
    endtask

    task automatic test_timeout();
        obs_t o;
        exp_t e;
        // Load granted, rvalid never comes: error after 4 cycles in REQ+WAIT_R.
        exp_q.push_back('{data: 32'h0, rd: 5'd9, err: 1'b1, lat: 5});
        do_xact(1'b0, 3'b010, 32'h300, 32'h0, 5'd9, 0, 0, 32'h0, o);
        e = exp_q.pop_front();
        vec_n++;
        if (!o.seen || o.lat != e.lat || o.err !== e.err || o.data !== e.data || o.rd !== e.rd) begin
            miss_n++; $display("FAIL to_load_rsp: got seen=%b lat=%0d err=%b data=%h rd=%0d, want lat=%0d err=1 data=0 rd=%0d",
                               o.seen, o.lat, o.err, o.data, o.rd, e.lat, e.rd);
        end
        // Late rvalid while idle must not produce another response.
        for (int k = 0; k < 3; k++) begin
            tick();
            i_mem_rvalid = (k < 2);
            i_mem_rdata  = 32'hBAD0BAD0;
            vec_n++;
            if (o_rsp_vld !== 1'b0 || lsu_READY !== 1'b1) begin
                miss_n++; $display("FAIL to_late_rvalid%0d: got rsp_vld=%b ready=%b, want 0 1", k, o_rsp_vld, lsu_READY);
            end
        end
        i_mem_rvalid = 1'b0;
        // Store never granted: request held for exactly 4 cycles.
        exp_q.push_back('{data: 32'h0, rd: 5'd10, err: 1'b1, lat: 5});
        do_xact(1'b1, 3'b010, 32'h304, 32'h11111111, 5'd10, -1, 0, 32'h0, o);
        e = exp_q.pop_front();
        vec_n++;
        if (!o.seen || o.lat != e.lat || o.err !== e.err || o.rd !== e.rd || o.req_cnt != 4) begin
            miss_n++; $display("FAIL to_store: got seen=%b lat=%0d err=%b rd=%0d req_cycles=%0d, want lat=5 err=1 rd=10 req_cycles=4",
                               o.seen, o.lat, o.err, o.rd, o.req_cnt);
        end
        // rvalid on the timeout cycle wins.
        exp_q.push_back('{data: 32'h00000055, rd: 5'd11, err: 1'b0, lat: 5});
        do_xact(1'b0, 3'b100, 32'h308, 32'h0, 5'd11, 0, 3, 32'hAAAAAA55, o);
        e = exp_q.pop_front();
        vec_n++;
        if (!o.seen || o.lat != e.lat || o.err !== e.err || o.data !== e.data || o.rd !== e.rd) begin
            miss_n++; $display("FAIL to_rvalid_wins: got seen=%b lat=%0d err=%b data=%h rd=%0d, want lat=5 err=0 data=%h rd=11",
                               o.seen, o.lat, o.err, o.data, o.rd, e.data);
        end
    endtask

    task automatic test_rst_mid();
        obs_t o;
        exp_t e;
        tick();
        lsu_VALID = 1'b1; i_st_mem = 1'b0; i_funct3 = 3'b010; i_addr = 32'h200; i_rd = 5'd3;
        tick();
        lsu_VALID = 1'b0;
        vec_n++;
        if (o_mem_req !== 1'b1) begin
            miss_n++; $display("FAIL rstmid_req: got mem_req=%b want 1", o_mem_req);
        end
        i_mem_gnt = 1'b1;
        tick();
        i_mem_gnt = 1'b0;
        i_rst     = 1'b1;
        tick();
        vec_n++;
        if (o_rsp_vld !== 1'b0 || o_mem_req !== 1'b0 || lsu_READY !== 1'b0) begin
            miss_n++; $display("FAIL rstmid_in_rst: got rsp_vld=%b mem_req=%b ready=%b, want 0 0 0",
                               o_rsp_vld, o_mem_req, lsu_READY);
        end
        i_rst        = 1'b0;
        i_mem_rvalid = 1'b1;
        i_mem_rdata  = 32'h55555555;
        tick();
        i_mem_rvalid = 1'b0;
        vec_n++;
        if (lsu_READY !== 1'b1 || o_rsp_vld !== 1'b0) begin
            miss_n++; $display("FAIL rstmid_after: got ready=%b rsp_vld=%b, want 1 0", lsu_READY, o_rsp_vld);
        end
        tick();
        vec_n++;
        if (o_rsp_vld !== 1'b0) begin
            miss_n++; $display("FAIL rstmid_norsp: got rsp_vld=%b want 0", o_rsp_vld);
        end
        exp_q.push_back('{data: 32'h600DF00D, rd: 5'd4, err: 1'b0, lat: 3});
        do_xact(1'b0, 3'b010, 32'h204, 32'h0, 5'd4, 0, 1, 32'h600DF00D, o);
        e = exp_q.pop_front();
        vec_n++;
        if (!o.seen || o.lat != e.lat || o.err !== e.err || o.data !== e.data || o.rd !== e.rd) begin
            miss_n++; $display("FAIL rstmid_next: got seen=%b lat=%0d err=%b data=%h rd=%0d, want lat=3 err=0 data=%h rd=4",
                               o.seen, o.lat, o.err, o.data, o.rd, e.data);
        end
    endtask

    task automatic test_back_to_back();
        logic [2:0]  ld_f3[5] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
        logic        st;
        logic [2:0]  f3;
        logic [1:0]  off;
        logic [31:0] addr, rdata;
        int          gd, rv;
        obs_t        o;
        exp_t        e;
        for (int i = 0; i < 12; i++) begin
            st    = 1'($urandom_range(0, 1));
            f3    = st ? 3'($urandom_range(0, 2)) : ld_f3[$urandom_range(0, 4)];
            off   = 2'($urandom_range(0, 3));
            if (f3[1:0] == 2'b01) off[0] = 1'b0;
            if (f3[1:0] == 2'b10) off = 2'b00;
            addr  = 32'h1000 | ($urandom & 32'h0000_0FFC) | {30'h0, off};
            rdata = $urandom;
            gd    = $urandom_range(0, 1);
            rv    = $urandom_range(1, 2);
            exp_q.push_back('{data: st ? 32'h0 : exp_load(f3, off, rdata), rd: 5'(i),
                              err: 1'b0, lat: st ? gd + 2 : gd + 2 + rv});
            do_xact(st, f3, addr, $urandom, 5'(i), gd, rv, rdata, o);
            e = exp_q.pop_front();
            vec_n++;
            if (!o.seen || o.lat != e.lat || o.err !== e.err || o.data !== e.data || o.rd !== e.rd || o.rdy !== 1'b1) begin
                miss_n++; $display("FAIL b2b%0d st=%b f3=%b addr=%h: got seen=%b lat=%0d err=%b data=%h rd=%0d rdy=%b, want lat=%0d err=0 data=%h rd=%0d rdy=1",
                                   i, st, f3, addr, o.seen, o.lat, o.err, o.data, o.rd, o.rdy, e.lat, e.data, e.rd);
            end
        end
    endtask

    initial begin
        test_reset();
        test_stores();
        test_loads();
        test_errors();
        test_timeout();
        test_rst_mid();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vec_n, miss_n);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
